mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and load/store share one
// memory port, with alternating priority on ties and a per-access timeout.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iFetchReq,
  input  logic [ADDR_WIDTH-1:0] iFetchAddr,
  output logic [DATA_WIDTH-1:0] oFetchData,
  output logic                  oFetchValid,
  input  logic                  iDataReq,
  input  logic                  iDataWe,
  input  logic [ADDR_WIDTH-1:0] iDataAddr,
  input  logic [DATA_WIDTH-1:0] iDataWData,
  input  logic [3:0]            iDataCtrl,
  output logic [DATA_WIDTH-1:0] oDataRData,
  output logic                  oDataValid,
  output logic                  oErr,
  output logic                  oMemReq,
  output logic                  oMemWe,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [DATA_WIDTH-1:0] oMemWData,
  output logic [3:0]            oMemCtrl,
  input  logic                  iMemReady,
  input  logic [DATA_WIDTH-1:0] iMemRData
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_data_q, last_data_d;   // 1: last grant went to data
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_ctrl_q, mem_ctrl_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic                  data_valid_q, data_valid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

  logic grant_fetch, grant_data, done, abort;
  logic arb_en, arb_fetch, arb_data;

  // State register
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q     <= S_IDLE;
      last_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
    end
  end

  // Next state: completion/timeout detection and grant selection
  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;
    arb_en      = 1'b0;
    arb_fetch   = 1'b0;
    arb_data    = 1'b0;
    case (state_q)
      S_IDLE: begin
        arb_en    = 1'b1;
        arb_fetch = iFetchReq;
        arb_data  = iDataReq;
      end
      S_FETCH, S_DATA: begin
        if (iMemReady) begin
          // Back-to-back: the requester just served does not compete
          done      = 1'b1;
          arb_en    = 1'b1;
          arb_fetch = iFetchReq && (state_q != S_FETCH);
          arb_data  = iDataReq && (state_q != S_DATA);
          state_d   = S_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (arb_en) begin
      if (arb_fetch && arb_data) begin
        grant_data  = !last_data_q;
        grant_fetch = last_data_q;
      end else begin
        grant_fetch = arb_fetch;
        grant_data  = arb_data;
      end
    end
    if (grant_fetch) begin
      state_d     = S_FETCH;
      last_data_d = 1'b0;
    end else if (grant_data) begin
      state_d     = S_DATA;
      last_data_d = 1'b1;
    end
  end

  // Outputs: command latch, wait counter, read data capture and pulses
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    mem_req_d     = (state_d != S_IDLE);
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_ctrl_d    = mem_ctrl_q;
    fetch_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    err_d         = 1'b0;
    fetch_data_d  = fetch_data_q;
    data_rdata_d  = data_rdata_q;
    if ((state_q != S_IDLE) && !iMemReady) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    if (done || abort) begin
      err_d = abort;
      if (state_q == S_FETCH) begin
        fetch_valid_d = 1'b1;
        fetch_data_d  = abort ? '0 : iMemRData;
      end else begin
        data_valid_d = 1'b1;
        if (abort) begin
          data_rdata_d = '0;
        end else if (!mem_we_q) begin
          data_rdata_d = iMemRData;
        end
      end
    end
    if (grant_fetch) begin
      wait_cnt_d  = '0;
      mem_we_d    = 1'b0;
      mem_addr_d  = iFetchAddr;
      mem_wdata_d = '0;
      mem_ctrl_d  = 4'd0;
    end else if (grant_data) begin
      wait_cnt_d  = '0;
      mem_we_d    = iDataWe;
      mem_addr_d  = iDataAddr;
      mem_wdata_d = iDataWData;
      mem_ctrl_d  = iDataCtrl;
    end
  end

  // Datapath and output registers
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wait_cnt_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_ctrl_q    <= 4'd0;
      fetch_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      fetch_data_q  <= '0;
      data_rdata_q  <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_ctrl_q    <= mem_ctrl_d;
      fetch_valid_q <= fetch_valid_d;
      data_valid_q  <= data_valid_d;
      err_q         <= err_d;
      fetch_data_q  <= fetch_data_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign oMemReq     = mem_req_q;
  assign oMemWe      = mem_we_q;
  assign oMemAddr    = mem_addr_q;
  assign oMemWData   = mem_wdata_q;
  assign oMemCtrl    = mem_ctrl_q;
  assign oFetchValid = fetch_valid_q;
  assign oDataValid  = data_valid_q;
  assign oErr        = err_q;
  assign oFetchData  = fetch_data_q;
  assign oDataRData  = data_rdata_q;

endmodule
